// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the requester-side and RAM-side signals of the
// shared system RAM arbiter. The arbiter uses the slave modport; the
// requesters and the RAM model sit on the master side.
interface mem_arbiter_if #(
  parameter int AW = 16
);
  // CPU port
  logic          cpu_req;
  logic [AW-1:0] cpu_address;
  logic [7:0]    cpu_out;
  logic          cpu_we;
  logic [7:0]    cpu_in;
  logic          hold;
  // video fetch port
  logic          vga_req;
  logic [AW-1:0] vga_address;
  logic          vga_ack;
  logic [7:0]    vga_data;
  // DMA / blitter port
  logic          dma_req;
  logic [AW-1:0] dma_address;
  logic [7:0]    dma_wdata;
  logic          dma_we;
  logic          dma_ack;
  logic [7:0]    dma_rdata;
  // single-port RAM
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_out;
  logic          ram_we;
  logic [7:0]    ram_in;

  modport slave (
    input  cpu_req, cpu_address, cpu_out, cpu_we,
    input  vga_req, vga_address,
    input  dma_req, dma_address, dma_wdata, dma_we,
    input  ram_in,
    output cpu_in, hold,
    output vga_ack, vga_data,
    output dma_ack, dma_rdata,
    output ram_address, ram_out, ram_we
  );

  modport master (
    output cpu_req, cpu_address, cpu_out, cpu_we,
    output vga_req, vga_address,
    output dma_req, dma_address, dma_wdata, dma_we,
    output ram_in,
    input  cpu_in, hold,
    input  vga_ack, vga_data,
    input  dma_ack, dma_rdata,
    input  ram_address, ram_out, ram_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM (1-cycle read latency)
// between the 6502 core, the video fetch port and a DMA/blitter port.
// One access per clock; video has fixed priority except when the CPU has
// been denied MAX_STALL consecutive cycles; CPU and DMA alternate on ties.
// Read data returns with an ack pulse in the cycle after the grant.
// Optional build macro ARB_PERF_EN adds 32-bit slot/stall counters.
module mem_arbiter #(
  parameter int MAX_STALL = 4,
  parameter int AW        = 16
) (
  input  logic        clock,
  input  logic        reset,
  mem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0] perf_vga,
  output logic [31:0] perf_cpu,
  output logic [31:0] perf_dma,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [3:0]    STALL_LIMIT = 4'(MAX_STALL);
  localparam logic [AW-1:0] ADDR_IDLE   = '0;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_t;

  owner_t     grant_s;
  owner_t     resp_owner_r;
  logic       resp_we_r;        // write strobe of the slot now returning
  logic       last_rr_r;        // 1 = DMA took the last CPU/DMA slot
  logic [3:0] stall_cnt_r;
  logic [3:0] stall_cnt_nxt_s;
  logic [7:0] cpu_in_r;
  logic [7:0] vga_data_r;
  logic [7:0] dma_rdata_r;

  // Slot grant: anti-starvation CPU, then video, then CPU/DMA round-robin.
  // No slot is granted while reset is asserted.
  always_comb begin
    grant_s = OWN_NONE;
    if (reset) begin
      grant_s = OWN_NONE;
    end else if (bus.cpu_req && (stall_cnt_r == STALL_LIMIT)) begin
      grant_s = OWN_CPU;
    end else if (bus.vga_req) begin
      grant_s = OWN_VGA;
    end else if (bus.cpu_req && bus.dma_req) begin
      grant_s = last_rr_r ? OWN_CPU : OWN_DMA;
    end else if (bus.cpu_req) begin
      grant_s = OWN_CPU;
    end else if (bus.dma_req) begin
      grant_s = OWN_DMA;
    end else begin
      grant_s = OWN_NONE;
    end
  end

  // RAM address/data/strobe mux from the granted requester.
  always_comb begin
    bus.ram_address = ADDR_IDLE;
    bus.ram_out     = 8'h00;
    bus.ram_we      = 1'b0;
    case (grant_s)
      OWN_CPU: begin
        bus.ram_address = bus.cpu_address;
        bus.ram_out     = bus.cpu_out;
        bus.ram_we      = bus.cpu_we;
      end
      OWN_VGA: begin
        bus.ram_address = bus.vga_address;
      end
      OWN_DMA: begin
        bus.ram_address = bus.dma_address;
        bus.ram_out     = bus.dma_wdata;
        bus.ram_we      = bus.dma_we;
      end
      default: begin
        bus.ram_address = ADDR_IDLE;
      end
    endcase
  end

  // Denied-cycle counter for the CPU, saturating at the forced-slot limit.
  always_comb begin
    stall_cnt_nxt_s = stall_cnt_r;
    if (!bus.cpu_req || (grant_s == OWN_CPU)) begin
      stall_cnt_nxt_s = 4'd0;
    end else if (stall_cnt_r == STALL_LIMIT) begin
      stall_cnt_nxt_s = stall_cnt_r;
    end else begin
      stall_cnt_nxt_s = stall_cnt_r + 4'd1;
    end
  end

  // Arbitration state and response-pipeline owner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_owner_r <= OWN_NONE;
      resp_we_r    <= 1'b0;
      stall_cnt_r  <= 4'd0;
      last_rr_r    <= 1'b1;
    end else begin
      resp_owner_r <= grant_s;
      resp_we_r    <= bus.ram_we;
      stall_cnt_r  <= stall_cnt_nxt_s;
      if (grant_s == OWN_CPU) begin
        last_rr_r <= 1'b0;
      end else if (grant_s == OWN_DMA) begin
        last_rr_r <= 1'b1;
      end else begin
        last_rr_r <= last_rr_r;
      end
    end
  end

  // Capture returned read data so each port keeps its last value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_in_r    <= 8'h00;
      vga_data_r  <= 8'h00;
      dma_rdata_r <= 8'h00;
    end else begin
      case (resp_owner_r)
        OWN_VGA: vga_data_r  <= bus.ram_in;
        OWN_DMA: dma_rdata_r <= bus.ram_in;
        OWN_CPU: begin
          if (!resp_we_r) begin
            cpu_in_r <= bus.ram_in;
          end else begin
            cpu_in_r <= cpu_in_r;
          end
        end
        default: begin
          cpu_in_r <= cpu_in_r;
        end
      endcase
    end
  end

  // Port outputs: the RAM's registered read data is forwarded in the ack
  // cycle, the captured copy is shown otherwise.
  always_comb begin
    bus.hold      = (grant_s == OWN_CPU);
    bus.vga_ack   = (resp_owner_r == OWN_VGA);
    bus.dma_ack   = (resp_owner_r == OWN_DMA);
    bus.vga_data  = bus.vga_ack ? bus.ram_in : vga_data_r;
    bus.dma_rdata = bus.dma_ack ? bus.ram_in : dma_rdata_r;
    if ((resp_owner_r == OWN_CPU) && !resp_we_r) begin
      bus.cpu_in = bus.ram_in;
    end else begin
      bus.cpu_in = cpu_in_r;
    end
  end

`ifdef ARB_PERF_EN
  // Slot and CPU-stall counters, wrapping at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_vga   <= 32'd0;
      perf_cpu   <= 32'd0;
      perf_dma   <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      case (grant_s)
        OWN_VGA: perf_vga <= perf_vga + 32'd1;
        OWN_CPU: perf_cpu <= perf_cpu + 32'd1;
        OWN_DMA: perf_dma <= perf_dma + 32'd1;
        default: perf_vga <= perf_vga;
      endcase
      if (bus.cpu_req && !bus.hold) begin
        perf_stall <= perf_stall + 32'd1;
      end else begin
        perf_stall <= perf_stall;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a write-first
// synchronous RAM model. Inputs change 1 time unit after the rising edge,
// outputs are checked on the falling edge.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  mem_arbiter_if #(.AW(16)) bus ();

`ifdef ARB_PERF_EN
  logic [31:0] perf_vga, perf_cpu, perf_dma, perf_stall;
`endif

  mem_arbiter #(.MAX_STALL(4), .AW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_PERF_EN
    ,
    .perf_vga   (perf_vga),
    .perf_cpu   (perf_cpu),
    .perf_dma   (perf_dma),
    .perf_stall (perf_stall)
`endif
  );

  // Default RAM contents for locations never written.
  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  bit         written [0:65535];
  logic [7:0] mem     [0:65535];

  // Write-first synchronous RAM.
  always @(posedge clock) begin
    if (bus.ram_we) begin
      mem[bus.ram_address]     <= bus.ram_out;
      written[bus.ram_address] <= 1'b1;
      bus.ram_in               <= bus.ram_out;
    end else begin
      bus.ram_in <= written[bus.ram_address] ? mem[bus.ram_address] : pat(bus.ram_address);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    bus.cpu_req = 1'b0; bus.cpu_address = 16'h0000; bus.cpu_out = 8'h00; bus.cpu_we = 1'b0;
    bus.vga_req = 1'b0; bus.vga_address = 16'h0000;
    bus.dma_req = 1'b0; bus.dma_address = 16'h0000; bus.dma_wdata = 8'h00; bus.dma_we = 1'b0;
  endtask

  task automatic to_next();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hold"},      {31'd0, bus.hold},     32'd0);
    check({tag, "_vga_ack"},   {31'd0, bus.vga_ack},  32'd0);
    check({tag, "_dma_ack"},   {31'd0, bus.dma_ack},  32'd0);
    check({tag, "_cpu_in"},    {24'd0, bus.cpu_in},   32'd0);
    check({tag, "_vga_data"},  {24'd0, bus.vga_data}, 32'd0);
    check({tag, "_dma_rdata"}, {24'd0, bus.dma_rdata},32'd0);
    check({tag, "_ram_we"},    {31'd0, bus.ram_we},   32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    to_next();
    to_next();
    @(negedge clock);
    check_reset_outputs("rst");
    to_next();
    reset = 1'b0;

    // CPU alone reads 0x1234 then 0x1235
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h1234;
    @(negedge clock);
    check("cpu0_hold", {31'd0, bus.hold}, 32'd1);
    check("cpu0_addr", {16'd0, bus.ram_address}, 32'h1234);
    to_next();
    bus.cpu_address = 16'h1235;
    @(negedge clock);
    check("cpu1_hold", {31'd0, bus.hold}, 32'd1);
    check("cpu1_data", {24'd0, bus.cpu_in}, 32'hA5);
    to_next();
    bus.cpu_req = 1'b0;
    @(negedge clock);
    check("cpu2_data", {24'd0, bus.cpu_in}, {24'd0, pat(16'h1235)});
    check("cpu2_hold", {31'd0, bus.hold}, 32'd0);
    to_next();
    @(negedge clock);
    check("cpu3_keep", {24'd0, bus.cpu_in}, {24'd0, pat(16'h1235)});
    to_next();

    // VGA + CPU contention: VGA x4 then a forced CPU slot
    bus.vga_req = 1'b1; bus.vga_address = 16'h3000;
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check($sformatf("vc%0d_hold", k), {31'd0, bus.hold}, {31'd0, (k % 5) == 4});
      check($sformatf("vc%0d_ack", k), {31'd0, bus.vga_ack},
            {31'd0, (k > 0) && (((k - 1) % 5) != 4)});
      if (k > 0) check($sformatf("vc%0d_vdata", k), {24'd0, bus.vga_data}, {24'd0, pat(16'h3000)});
      if (k == 4) check("vc4_addr", {16'd0, bus.ram_address}, 32'h1234);
      if (k == 5) check("vc5_cpu_in", {24'd0, bus.cpu_in}, 32'hA5);
      to_next();
    end

    // Reset with a VGA response pending: the ack is dropped
    idle_all();
    reset = 1'b1;
    @(negedge clock);
    check("rst2_vga_ack", {31'd0, bus.vga_ack}, 32'd0);
    check("rst2_cpu_in", {24'd0, bus.cpu_in}, 32'd0);
    to_next();
    reset = 1'b0;

    // CPU + DMA: alternating, CPU first after reset
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h1234;
    bus.dma_req = 1'b1; bus.dma_address = 16'h4000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check($sformatf("rr%0d_hold", k), {31'd0, bus.hold}, {31'd0, (k % 2) == 0});
      check($sformatf("rr%0d_dack", k), {31'd0, bus.dma_ack}, {31'd0, (k >= 2) && ((k % 2) == 0)});
      check($sformatf("rr%0d_addr", k), {16'd0, bus.ram_address},
            ((k % 2) == 0) ? 32'h1234 : 32'h4000);
      if (k >= 2 && (k % 2) == 0)
        check($sformatf("rr%0d_rdata", k), {24'd0, bus.dma_rdata}, {24'd0, pat(16'h4000)});
      to_next();
    end
    idle_all();
    @(negedge clock);
    check("rr_last_dack", {31'd0, bus.dma_ack}, 32'd1);
    to_next();

    // DMA write 0x5A to 0x0200, CPU reads it back in the next slot
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_address = 16'h0200; bus.dma_wdata = 8'h5A;
    @(negedge clock);
    check("dw_we",   {31'd0, bus.ram_we}, 32'd1);
    check("dw_addr", {16'd0, bus.ram_address}, 32'h0200);
    check("dw_data", {24'd0, bus.ram_out}, 32'h5A);
    check("dw_dack", {31'd0, bus.dma_ack}, 32'd0);
    to_next();
    bus.dma_req = 1'b0; bus.dma_we = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h0200; bus.cpu_we = 1'b0;
    @(negedge clock);
    check("dw_ack",   {31'd0, bus.dma_ack}, 32'd1);
    check("dw_rdata", {24'd0, bus.dma_rdata}, 32'h5A);
    check("raw_hold", {31'd0, bus.hold}, 32'd1);
    to_next();
    bus.cpu_req = 1'b0;
    @(negedge clock);
    check("raw_cpu_in", {24'd0, bus.cpu_in}, 32'h5A);
    check("raw_dack0",  {31'd0, bus.dma_ack}, 32'd0);
    to_next();

    // CPU write 0x77 to 0x0300 leaves cpu_in alone; read-back sees it
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h0300; bus.cpu_out = 8'h77; bus.cpu_we = 1'b1;
    @(negedge clock);
    check("cw_we", {31'd0, bus.ram_we}, 32'd1);
    to_next();
    bus.cpu_we = 1'b0;
    @(negedge clock);
    check("cw_keep", {24'd0, bus.cpu_in}, 32'h5A);
    to_next();
    bus.cpu_req = 1'b0;
    @(negedge clock);
    check("cw_read", {24'd0, bus.cpu_in}, 32'h77);
    to_next();

    // Reset asserted while a VGA read is granted, all requests held high
    bus.vga_req = 1'b1; bus.vga_address = 16'h5000;
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h1234;
    bus.dma_req = 1'b1; bus.dma_address = 16'h4000;
    @(negedge clock);
    check("rv_addr", {16'd0, bus.ram_address}, 32'h5000);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rv");
    check("rv_ram_addr", {16'd0, bus.ram_address}, 32'h0000);
    to_next();
    reset = 1'b0;
    @(negedge clock);
    check("rv_post_ack",  {31'd0, bus.vga_ack}, 32'd0);
    check("rv_post_addr", {16'd0, bus.ram_address}, 32'h5000);
    check("rv_post_hold", {31'd0, bus.hold}, 32'd0);
    to_next();
    @(negedge clock);
    check("rv_ack",  {31'd0, bus.vga_ack}, 32'd1);
    check("rv_data", {24'd0, bus.vga_data}, {24'd0, pat(16'h5000)});
    to_next();

`ifdef ARB_PERF_EN
    idle_all();
    reset = 1'b1;
    to_next();
    reset = 1'b0;
    bus.vga_req = 1'b1; bus.vga_address = 16'h3000;
    bus.cpu_req = 1'b1; bus.cpu_address = 16'h1234;
    for (int k = 0; k < 10; k++) to_next();
    idle_all();
    @(negedge clock);
    check("perf_vga",   perf_vga,   32'd8);
    check("perf_cpu",   perf_cpu,   32'd2);
    check("perf_dma",   perf_dma,   32'd0);
    check("perf_stall", perf_stall, 32'd8);
    to_next();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 64 KB system RAM (synchronous read, 1-cycle latency) between three requesters:
  - the 6502 core;
  - the video DAC fetch port;
  - a DMA/blitter port.
- Issues one RAM access per clock. Returns read data one cycle later with an ack.
- Stalls the CPU through its hold input.
- Fixed priority for video, with a CPU anti-starvation guard. CPU and DMA alternate round-robin.

Parameters:
- MAX_STALL, 4: consecutive cycles the CPU may be denied before it is forced a slot over video (range 1..15).
- AW, 16: address width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU wants a slot (core ties this to 1)
- cpu_address  in  AW  CPU address
- cpu_out  in  8  CPU write data
- cpu_we  in  1  CPU write strobe
- cpu_in  out  8  CPU read data, held until the next CPU read returns
- hold  out  1  1 = CPU granted this cycle and may advance; 0 = CPU frozen
- vga_req  in  1  video fetch request
- vga_address  in  AW  video address
- vga_ack  out  1  pulse: vga_data valid
- vga_data  out  8  video read data
- dma_req  in  1  DMA request (held until acked)
- dma_address  in  AW  DMA address
- dma_wdata  in  8  DMA write data
- dma_we  in  1  DMA write strobe
- dma_ack  out  1  pulse: DMA access completed, dma_rdata valid for reads
- dma_rdata  out  8  DMA read data
- ram_address  out  AW  RAM address
- ram_out  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_in  in  8  RAM read data, registered by RAM, valid one cycle after its address

Behaviour:
- Grant is combinational from current requests plus registered state: last_rr (CPU/DMA round-robin pointer) and stall_cnt (4 bit).
- Priority in each cycle:
  - (1) CPU if cpu_req and stall_cnt == MAX_STALL.
  - (2) else VGA if vga_req.
  - (3) else CPU/DMA if only one requests.
  - (4) if both request: the one not equal to last_rr.
  - (5) else idle.
- ram_address, ram_out and ram_we are muxed from the granted requester. Idle: ram_address = 0, ram_we = 0. ram_we = granted requester's we; VGA never writes.
- hold = grant==CPU.
- stall_cnt:
  - increments (saturating at MAX_STALL) when cpu_req and not granted;
  - clears when CPU is granted or cpu_req = 0.
- last_rr updates only on CPU or DMA grants.
- Response pipeline: register resp_owner (NONE/CPU/VGA/DMA) = grant. In the next cycle:
  - VGA: vga_ack = 1, vga_data = ram_in.
  - DMA: dma_ack = 1, dma_rdata = ram_in; ack also for writes.
  - CPU: cpu_in <= ram_in. CPU writes do not update cpu_in.
- vga_data, dma_rdata and cpu_in are registered and retain their value otherwise.
- Acks are single-cycle pulses. Back-to-back grants give back-to-back acks.
- Requesters must hold address/data/we stable until granted. DMA drops dma_req in the ack cycle or issues a new access.
- Read-after-write to the same address in consecutive slots returns the new data; the RAM is write-first.
- Reset (async):
  - hold = 0; all acks 0; cpu_in, vga_data, dma_rdata = 0.
  - resp_owner = NONE; stall_cnt = 0; last_rr = DMA, so CPU wins the first tie.
  - ram_we = 0.
  - An access granted in the cycle of reset assertion produces no ack.
- Reset deasserting with all requests high: first slot VGA.

Optional Feature:
- ARB_PERF_EN.
- Defined:
  - adds outputs perf_vga, perf_cpu, perf_dma, perf_stall (each 32 bit).
  - Grant counters increment per granted slot. perf_stall increments per cycle with cpu_req and hold = 0.
  - All wrap at 2^32 and clear on reset.
- Undefined: ports absent, no counter logic.

Test Plan:
- CPU only, cpu_req = 1, read 0x1234 holding 0xA5 -> hold = 1 every cycle; cpu_in = 0xA5 one cycle after the address.
- vga_req = 1 continuously, cpu_req = 1, MAX_STALL = 4 -> grant pattern VGA,VGA,VGA,VGA,CPU repeating. hold low 4 cycles then high 1; vga_ack pattern 1,1,1,1,0.
- CPU and DMA both requesting, no VGA -> grants alternate CPU,DMA,CPU,DMA starting with CPU after reset. dma_ack every second cycle.
- DMA write 0x5A to 0x0200, then CPU read 0x0200 next slot -> cpu_in = 0x5A; dma_ack pulse 1 cycle after the write slot.
- Assert reset while a VGA read is granted -> no vga_ack after reset; all outputs at reset values; first post-reset slot follows the priority rules.
- ARB_PERF_EN: 10 cycles of VGA+CPU contention, MAX_STALL = 4 -> perf_vga = 8, perf_cpu = 2, perf_stall = 8.
